soc_top_core: RTL and testbench

//  Minimal SoC core: an SPI slave loads a 32-word instruction RAM; a tiny accumulator CPU runs it and drives a 32-bit GPIO.
//  Top of the core hierarchy; external pins are SPI (quad-capable pinout, single-lane used) and GPIO.

---
 rtl/soc_core_pkg.sv | 38 +++
 rtl/spi_slave_rx.sv | 129 ++++++++++++
 rtl/soc_top_core.sv | 142 ++++++++++++++
 tb/tb_soc_top_core.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/soc_core_pkg.sv
// Shared constants and types for the SPI-loaded accumulator core.
// Opcodes, SPI commands, SPI FSM states and the write bundle.
package soc_core_pkg;

  localparam logic [31:0] MEM_BASE_DEF = 32'h0000_0080;

  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_ADDI = 8'h02;
  localparam logic [7:0] OP_OUT  = 8'h03;
  localparam logic [7:0] OP_JMP  = 8'h04;
  localparam logic [31:0] INSTR_HALT = 32'h0000_0FFF;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_CMD,
    SPI_ADDR,
    SPI_DATA,
    SPI_DONE
  } spi_state_e;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
  } spi_wr_t;

  function automatic logic in_window(
    input logic [31:0] a,
    input logic [31:0] base,
    input logic [31:0] bytes
  );
    return (a >= base) && ((a - base) < bytes);
  endfunction

endpackage

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: synchronisers, cmd/addr/data shifter, write strobe.
// SPI_RDBACK_EN adds the read-word command shifting out on sdo.
module spi_slave_rx
  import soc_core_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sclk_i,
  input  logic        cs_i,
  input  logic        sdi_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_addr_o,
  output logic        sdo_o,
  output spi_wr_t     wr_o
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic sclk_s, cs_s, sdi_s, sclk_q, rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sdi_sync  <= '0;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_i};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi_i};
      sclk_q    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_q;

  spi_state_e state, state_n;
  logic [4:0]  cnt;
  logic [31:0] shreg, shin;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic last_cmd, last_word, shifting;

  assign shin      = {shreg[30:0], sdi_s};
  assign last_cmd  = (cnt == 5'd7);
  assign last_word = (cnt == 5'd31);
  assign shifting  = !cs_s && (state == SPI_CMD ||
                     state == SPI_ADDR || state == SPI_DATA);
  assign rd_addr_o = addr;

  always_comb begin
    state_n = state;
    if (cs_s) begin
      state_n = SPI_IDLE;
    end else begin
      unique case (state)
        SPI_IDLE: state_n = SPI_CMD;
        SPI_CMD:  if (rise && last_cmd) state_n = SPI_ADDR;
        SPI_ADDR: if (rise && last_word) state_n = SPI_DATA;
        SPI_DATA: if (rise && last_word) state_n = SPI_DONE;
        SPI_DONE: state_n = SPI_DONE;
        default:  state_n = SPI_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= SPI_IDLE;
      cnt   <= '0;
      shreg <= '0;
      cmd   <= '0;
      addr  <= '0;
      wr_o  <= '0;
    end else begin
      state   <= state_n;
      wr_o.en <= 1'b0;
      if (state_n != state) cnt <= '0;
      else if (rise) cnt <= cnt + 5'd1;
      if (rise && shifting) shreg <= shin;
      if (rise && shifting && state == SPI_CMD && last_cmd)
        cmd <= shin[7:0];
      if (rise && shifting && state == SPI_ADDR && last_word)
        addr <= shin;
      // Strobe fires on the final data bit, as the FSM enters DONE
      if (rise && shifting && state == SPI_DATA && last_word &&
          cmd == CMD_WRITE)
        wr_o <= '{en: 1'b1, addr: addr, data: shin};
    end
  end

`ifdef SPI_RDBACK_EN
  logic [31:0] rd_shift;
  logic        rd_load;
  logic        fall;

  assign fall = ~sclk_s & sclk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_shift <= '0;
      rd_load  <= 1'b0;
      sdo_o    <= 1'b0;
    end else begin
      rd_load <= rise && shifting && state == SPI_ADDR &&
                 last_word && cmd == CMD_READ;
      if (cs_s) begin
        sdo_o <= 1'b0;
      end else if (rd_load) begin
        rd_shift <= rd_data_i;
      end else if (fall && state == SPI_DATA && cmd == CMD_READ) begin
        sdo_o    <= rd_shift[31];
        rd_shift <= {rd_shift[30:0], 1'b0};
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^rd_data_i;
  assign sdo_o     = 1'b0;
`endif

endmodule

// File: rtl/soc_top_core.sv
// SPI-loaded 32-word instruction RAM, accumulator CPU and GPIO register.
// SPI_RDBACK_EN enables SPI read-back of RAM words on spi_sdo0.
module soc_top_core
  import soc_core_pkg::*;
#(
  parameter int          MEM_WORDS   = 32,
  parameter logic [31:0] MEM_BASE    = MEM_BASE_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  input  logic        en_ifetch_i,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  output logic [1:0]  spi_mode,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3,
  output logic [31:0] gpio_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  spi_wr_t     spi_wr;
  logic [31:0] rd_addr, rd_data;

  spi_slave_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_spi (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sclk_i   (spi_sclk),
    .cs_i     (spi_cs),
    .sdi_i    (spi_sdi0),
    .rd_data_i(rd_data),
    .rd_addr_o(rd_addr),
    .sdo_o    (spi_sdo0),
    .wr_o     (spi_wr)
  );

  assign spi_mode = 2'b00;
  assign spi_sdo1 = 1'b0;
  assign spi_sdo2 = 1'b0;
  assign spi_sdo3 = 1'b0;

  logic [31:0] ram [MEM_WORDS];
  logic [31:0] wr_off, rd_off, pc_off;
  logic        wr_hit;

  assign wr_off = spi_wr.addr - MEM_BASE;
  assign rd_off = rd_addr - MEM_BASE;
  assign wr_hit = spi_wr.en &&
                  in_window(spi_wr.addr, MEM_BASE, MEM_BYTES);

  always_ff @(posedge clk_i) begin
    if (wr_hit) ram[wr_off[AW+1:2]] <= spi_wr.data;
  end

  assign rd_data = in_window(rd_addr, MEM_BASE, MEM_BYTES) ?
                   ram[rd_off[AW+1:2]] : 32'h0;

  logic [31:0] pc, acc;
  logic        halted, fen_q, fen_rise, run;
  logic [AW-1:0] pc_idx, idx_inc;
  logic [31:0] instr, imm, pc_seq;
  logic [7:0]  op;

  assign pc_off   = pc - MEM_BASE;
  assign pc_idx   = pc_off[AW+1:2];
  assign idx_inc  = pc_idx + AW'(1);
  assign pc_seq   = MEM_BASE + {{(30-AW){1'b0}}, idx_inc, 2'b00};
  assign instr    = ram[pc_idx];
  assign op       = instr[31:24];
  assign imm      = {16'h0, instr[15:0]};
  assign fen_rise = fetch_enable_i & ~fen_q;
  // A same-cycle SPI write owns the RAM port, so fetch stalls
  assign run = fetch_enable_i && en_ifetch_i && !halted &&
               !wr_hit && !fen_rise;

  logic is_ldi, is_addi, is_out, is_jmp, is_halt;
  assign is_halt = (instr == INSTR_HALT);
  assign is_ldi  = (op == OP_LDI);
  assign is_addi = (op == OP_ADDI);
  assign is_out  = (op == OP_OUT);
  assign is_jmp  = (op == OP_JMP);

  logic [31:0] pc_n, acc_n, gpio_n;
  logic        halt_n;

  always_comb begin
    pc_n   = pc_seq;
    acc_n  = acc;
    gpio_n = gpio_o;
    halt_n = halted;
    unique case (1'b1)
      is_ldi:  acc_n  = imm;
      is_addi: acc_n  = acc + imm;
      is_out:  gpio_n = acc;
      is_jmp:  pc_n   = MEM_BASE + {25'h0, imm[4:0], 2'b00};
      is_halt: begin
        halt_n = 1'b1;
        pc_n   = pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc     <= MEM_BASE;
      acc    <= '0;
      halted <= 1'b0;
      gpio_o <= '0;
      fen_q  <= 1'b0;
    end else begin
      fen_q <= fetch_enable_i;
      if (fen_rise) begin
        pc     <= MEM_BASE;
        halted <= 1'b0;
      end else if (run) begin
        pc     <= pc_n;
        acc    <= acc_n;
        gpio_o <= gpio_n;
        halted <= halt_n;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{spi_sdi1, spi_sdi2, spi_sdi3,
                         wr_off[31:AW+2], wr_off[1:0],
                         rd_off[31:AW+2], rd_off[1:0],
                         pc_off[31:AW+2], pc_off[1:0]};

endmodule

// File: tb/tb_soc_top_core.sv
// Directed bench: SPI program load, guarded writes, run/pause/rerun,
// JMP, reset during execution and (SPI_RDBACK_EN) word read-back.
module tb_soc_top_core;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_i, fetch_enable_i, en_ifetch_i;
  logic spi_sclk, spi_cs, spi_sdi0;
  logic spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
  logic [1:0]  spi_mode;
  logic [31:0] gpio_o;
  logic [31:0] rx;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  soc_top_core dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .fetch_enable_i(fetch_enable_i),
    .en_ifetch_i   (en_ifetch_i),
    .spi_sclk      (spi_sclk),
    .spi_cs        (spi_cs),
    .spi_mode      (spi_mode),
    .spi_sdi0      (spi_sdi0),
    .spi_sdi1      (1'b0),
    .spi_sdi2      (1'b0),
    .spi_sdi3      (1'b0),
    .spi_sdo0      (spi_sdo0),
    .spi_sdo1      (spi_sdo1),
    .spi_sdo2      (spi_sdo2),
    .spi_sdo3      (spi_sdo3),
    .gpio_o        (gpio_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic spi_frame(input logic [7:0]  c,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input int          nbits,
                           output logic [31:0] r);
    logic [71:0] f;
    f = {c, a, d};
    r = '0;
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_sdi0 = f[71-i];
      repeat (HALF) @(negedge clk);
      if (i >= 40) r = {r[30:0], spi_sdo0};
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs   = 1'b1;
    spi_sdi0 = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_wr(input logic [7:0] c,
                        input logic [31:0] a,
                        input logic [31:0] d);
    logic [31:0] r;
    spi_frame(c, a, d, 72, r);
  endtask

  task automatic restart();
    fetch_enable_i = 1'b0;
    repeat (2) @(negedge clk);
    fetch_enable_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    fetch_enable_i = 1'b0;
    en_ifetch_i = 1'b0;
    spi_sclk = 1'b0;
    spi_cs = 1'b1;
    spi_sdi0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    chk("rst_gpio", gpio_o, 32'h0);
    chk("rst_pc", dut.pc, 32'h80);
    chk("rst_halted", 32'(dut.halted), 32'h0);
    chk("rst_sdo", {30'h0, spi_mode}, 32'h0);
    chk("rst_sdo0", {28'h0, spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3},
        32'h0);

    spi_wr(8'h02, 32'h80, 32'h0100_000A);
    spi_wr(8'h02, 32'h84, 32'h0200_0014);
    spi_wr(8'h02, 32'h88, 32'h0300_0000);
    spi_wr(8'h02, 32'h8F, 32'h0000_0FFF);
    spi_wr(8'h02, 32'h90, 32'h0);
    spi_wr(8'h02, 32'hFC, 32'h0);
    chk("ld_w0", dut.ram[0], 32'h0100_000A);
    chk("ld_w1", dut.ram[1], 32'h0200_0014);
    chk("ld_w2", dut.ram[2], 32'h0300_0000);
    chk("ld_w3_lowbits", dut.ram[3], 32'h0000_0FFF);

    spi_wr(8'h02, 32'h7C, 32'hDEAD_BEEF);
    spi_wr(8'h02, 32'h100, 32'hCAFE_F00D);
    spi_wr(8'h05, 32'h90, 32'h0100_0063);
    chk("oor_low", dut.ram[31], 32'h0);
    chk("oor_high", dut.ram[0], 32'h0100_000A);
    chk("bad_cmd", dut.ram[4], 32'h0);

    spi_frame(8'h02, 32'h84, 32'h0100_0077, 20, rx);
    chk("abort", dut.ram[1], 32'h0200_0014);
    spi_wr(8'h02, 32'h94, 32'h0000_0FFF);
    chk("after_abort", dut.ram[5], 32'h0000_0FFF);

    fetch_enable_i = 1'b1;
    en_ifetch_i = 1'b1;
    repeat (3) @(negedge clk);
    en_ifetch_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pause_pc", dut.pc, 32'h88);
    chk("pause_gpio", gpio_o, 32'h0);
    en_ifetch_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("run_gpio", gpio_o, 32'd30);
    chk("run_halted", 32'(dut.halted), 32'h1);
    chk("run_pc", dut.pc, 32'h8C);

    spi_wr(8'h02, 32'h84, 32'h0200_0015);
    restart();
    @(negedge clk);
    chk("rerun_pc", dut.pc, 32'h80);
    chk("rerun_halted", 32'(dut.halted), 32'h0);
    repeat (10) @(negedge clk);
    chk("rerun_gpio", gpio_o, 32'd31);

    spi_wr(8'h02, 32'h84, 32'h0200_0014);
    spi_wr(8'h02, 32'h8C, 32'h0400_0005);
    restart();
    repeat (10) @(negedge clk);
    chk("jmp_gpio", gpio_o, 32'd30);
    chk("jmp_pc", dut.pc, 32'h94);
    chk("jmp_halted", 32'(dut.halted), 32'h1);

    restart();
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_run_gpio", gpio_o, 32'h0);
    chk("rst_run_pc", dut.pc, 32'h80);
    chk("rst_run_halted", 32'(dut.halted), 32'h0);
    rst_i = 1'b0;
    fetch_enable_i = 1'b0;
    @(negedge clk);

`ifdef SPI_RDBACK_EN
    spi_frame(8'h0B, 32'h84, 32'h0, 72, rx);
    chk("rd_84", rx, 32'h0200_0014);
    spi_frame(8'h0B, 32'h100, 32'h0, 72, rx);
    chk("rd_oor", rx, 32'h0);
`else
    spi_frame(8'h0B, 32'h84, 32'h0, 72, rx);
    chk("rd_disabled", rx, 32'h0);
    chk("rd_no_write", dut.ram[1], 32'h0200_0014);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
